// File: rtl/c17_bist_pkg.sv
// c17_bist_pkg
// Shared types, widths, polynomial taps and next-state helpers for the
// c17 BIST controller.
//   bist_state_e : controller states (IDLE, RUN, DONE)
//   lfsr_next()  : one step of the 5-bit Fibonacci pattern generator
//   misr_next()  : one step of the 8-bit response compactor
package c17_bist_pkg;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 8;

  // x^5 + x^2 + 1: feedback from bits 4 and 2
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
  // x^8 + x^6 + x^5 + x^4 + 1: feedback from bits 7, 5, 4 and 3
  localparam logic [MISR_W-1:0] MISR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  // resp = {N22, N23}; N23 lands in bit 0
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                  input logic [1:0]        resp);
    return {m[MISR_W-2:0], ^(m & MISR_TAPS)} ^ {{(MISR_W-2){1'b0}}, resp};
  endfunction

endpackage

// File: rtl/c17_bist_ctrl_if.sv
// c17_bist_ctrl_if
// Handshake between the test-access logic (master) and the BIST
// controller (slave).
//   bist_start : one-cycle run request          (master -> slave)
//   bist_abort : cancel the current run         (master -> slave)
//   bist_busy  : run in progress                (slave -> master)
//   bist_done  : run finished, result valid     (slave -> master)
//   bist_pass  : signature matched golden value (slave -> master)
//   bist_sig   : live MISR contents             (slave -> master)
interface c17_bist_ctrl_if;
  import c17_bist_pkg::*;

  logic              bist_start;
  logic              bist_abort;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_pass;
  logic [MISR_W-1:0] bist_sig;

  modport master (
    output bist_start, bist_abort,
    input  bist_busy, bist_done, bist_pass, bist_sig
  );

  modport slave (
    input  bist_start, bist_abort,
    output bist_busy, bist_done, bist_pass, bist_sig
  );
endinterface

// File: rtl/c17_bist_ctrl_core.sv
// c17
// ISCAS-85 c17 benchmark: six NAND2 gates, purely combinational.
//   N1, N2, N3, N6, N7 : primary inputs
//   N22, N23           : primary outputs
module c17 (
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N6,
  input  logic N7,
  output logic N22,
  output logic N23
);
  logic n10, n11, n16, n19;

  assign n10 = ~(N1 & N3);
  assign n11 = ~(N3 & N6);
  assign n16 = ~(N2 & n11);
  assign n19 = ~(n11 & N7);
  assign N22 = ~(n10 & n16);
  assign N23 = ~(n16 & n19);
endmodule

// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl
// Built-in self-test wrapper around the c17 core. In functional mode the
// five primary inputs pass straight to the core; during a run the core is
// driven by a 5-bit LFSR and its two outputs are compacted into an 8-bit
// MISR. Pass/fail is registered on the last pattern.
//   CK, RST            : clock, asynchronous active-high reset
//   bif (slave)        : start/abort in; busy/done/pass/signature out
//   N1, N2, N3, N6, N7 : functional core inputs
//   N22, N23           : core outputs (always live)
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | functional mode, waiting for bist_start
// ST_RUN  | LFSR drives the core, MISR compacts, count advances
// ST_DONE | result held (done/pass/sig), functional mode, restartable
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int                NUM_PATTERNS = 31,
  parameter logic [LFSR_W-1:0] SEED         = 5'b00001,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic                  CK,
  input  logic                  RST,
  c17_bist_ctrl_if.slave        bif,
  input  logic                  N1,
  input  logic                  N2,
  input  logic                  N3,
  input  logic                  N6,
  input  logic                  N7,
  output logic                  N22,
  output logic                  N23
);

  localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  bist_state_e       state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [MISR_W-1:0] misr_q;
  logic [MISR_W-1:0] misr_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              pass_q;

  logic              run_load;
  logic              run_step;
  logic              run_end;
  logic              run_kill;

  logic [LFSR_W-1:0] core_in;
  logic              core_n22;
  logic              core_n23;

  // Core input mux: pattern generator owns the core only while running
  assign core_in = (state_q == ST_RUN) ? lfsr_q : {N1, N2, N3, N6, N7};

  c17 u_core (
    .N1  (core_in[4]),
    .N2  (core_in[3]),
    .N3  (core_in[2]),
    .N6  (core_in[1]),
    .N7  (core_in[0]),
    .N22 (core_n22),
    .N23 (core_n23)
  );

  assign N22 = core_n22;
  assign N23 = core_n23;

  // Zero-latency capture: the response to the current pattern is folded in
  // on the same edge the LFSR advances.
  assign misr_nxt = misr_next(misr_q, {core_n22, core_n23});

  always_ff @(posedge CK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    run_load = 1'b0;
    run_step = 1'b0;
    run_end  = 1'b0;
    run_kill = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bif.bist_start) begin
          state_d  = ST_RUN;
          run_load = 1'b1;
        end
      end
      ST_RUN: begin
        // abort outranks both a stray start and the end of the run
        if (bif.bist_abort) begin
          state_d  = ST_IDLE;
          run_kill = 1'b1;
        end else begin
          run_step = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            run_end = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bif.bist_start) begin
          state_d  = ST_RUN;
          run_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An aborted run leaves the partial signature visible until the next start
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      lfsr_q <= SEED;
      misr_q <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (run_load) begin
      lfsr_q <= SEED;
      misr_q <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (run_step) begin
      lfsr_q <= lfsr_next(lfsr_q);
      misr_q <= misr_nxt;
      cnt_q  <= cnt_q + 1'b1;
      if (run_end) pass_q <= (misr_nxt == GOLDEN_SIG);
    end else if (run_kill) begin
      pass_q <= 1'b0;
    end
  end

  assign bif.bist_busy = (state_q == ST_RUN);
  assign bif.bist_done = (state_q == ST_DONE);
  assign bif.bist_pass = pass_q;
  assign bif.bist_sig  = misr_q;

endmodule

// File: doc/c17_bist_ctrl.md
# c17_bist_ctrl

Built-in self-test controller wrapped around the c17 combinational core. In functional mode it passes the five primary inputs straight to the core. On request it takes over the core inputs, applies a fixed number of pseudo-random patterns from a 5-bit LFSR, and compacts the two core outputs into an 8-bit MISR. It then reports done, pass/fail and the signature to the test-access logic above it.

## Interface
- NUM_PATTERNS, 31, patterns applied per run; legal range 1..255 (values above 31 repeat the LFSR sequence).
- SEED, 5'b00001, LFSR load value at run start; must be nonzero (bench asserts).
- GOLDEN_SIG, 8'h00, expected MISR value after NUM_PATTERNS patterns; filled from the bench model at integration.
- CK  in  1  single clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- bist_start  in  1  one-cycle request; honoured in IDLE and DONE only.
- bist_abort  in  1  cancels a run; honoured in RUN only; wins over end-of-run.
- N1, N2, N3, N6, N7  in  1 each  functional core inputs.
- N22, N23  out  1 each  core outputs, always driven by the core.
- bist_busy  out  1  high in RUN.
- bist_done  out  1  high in DONE.
- bist_pass  out  1  registered (MISR == GOLDEN_SIG) at end of run; valid while bist_done.
- bist_sig  out  8  current MISR contents.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: bist_start → RUN.
  - RUN: bist_abort → IDLE; after the NUM_PATTERNS-th pattern → DONE.
  - DONE: bist_start → RUN (restart); otherwise hold.
- Start accept: LFSR ← SEED, MISR ← 0, count ← 0.
- Core input mux:
  - In RUN: {N1,N2,N3,N6,N7} of the core = lfsr[4:0] (N1 = bit 4).
  - In IDLE and DONE: the functional ports.
- LFSR (x^5+x^2+1, Fibonacci): next = {q[3:0], q[4]^q[2]}. From 00001 the sequence is 00001, 00010, 00100, 01001, 10010, …; period 31.
- MISR (x^8+x^6+x^5+x^4+1): next = {m[6:0], m[7]^m[5]^m[4]^m[3]} ^ {6'b0, N22, N23}.
- Each RUN cycle: the MISR absorbs the core response to the current pattern, the LFSR advances, and count increments.
- Count width is $clog2(NUM_PATTERNS+1). The last pattern is applied when count == NUM_PATTERNS-1.
- On the RUN→DONE edge: bist_pass ← (next MISR == GOLDEN_SIG). The MISR and LFSR then freeze.
- Abort: returns to IDLE with bist_done=0 and bist_pass=0. bist_sig keeps its partial value until the next start.
- bist_start in RUN is ignored. bist_abort outside RUN is ignored. bist_start and bist_abort together in RUN: abort.

## Timing
- Reset values: state IDLE, LFSR=SEED, MISR=0, count=0. Outputs: bist_busy=0, bist_done=0, bist_pass=0, bist_sig=8'h00. N22/N23 follow the functional inputs through the core.
- With start sampled on edge k:
  - bist_busy is high from edge k through edge k+NUM_PATTERNS.
  - bist_done rises at edge k+NUM_PATTERNS; bist_pass is valid the same edge.
- The core is purely combinational, so pattern-to-capture latency is zero cycles.
- RST asserted mid-run: immediate return to reset values. There is no resume.
- bist_done stays high until the next accepted start or RST.

## Structure
- Package c17_bist_pkg holds:
  - state enum;
  - LFSR_W=5 and MISR_W=8;
  - tap constants;
  - functions lfsr_next() and misr_next().
- The only sub-module is the existing c17 core instance, used as the circuit under test.
- LFSR, MISR, counter and FSM stay inline in c17_bist_ctrl.

## Test plan
- Reset then idle, functional inputs N1..N7 = 0,0,0,0,1 → N22=0, N23=1; bist_busy/done/pass=0; bist_sig=8'h00.
- Start with SEED=5'b00001, NUM_PATTERNS=1 → core sees 00001, response 01; bist_sig=8'h01 at edge k+1; bist_done high at edge k+1.
- Full run, NUM_PATTERNS=31, GOLDEN_SIG from the bench model → bist_busy high exactly 31 cycles; LFSR back at 00001; bist_done=1; bist_pass=1; bist_sig matches the model.
- Same run with GOLDEN_SIG bit 0 flipped → bist_pass=0; bist_sig unchanged.
- bist_abort asserted at count 10 → IDLE next edge, bist_done=0. A following start gives a signature identical to the full-run value.
- RST pulsed at count 5, then bist_start in DONE after a clean run → all outputs return to reset values. Restart reloads SEED and the MISR and reproduces the same signature.
